// File: rtl/min_max_array_loader_pkg.sv
// Shared definitions for the min/max array loader and the min/max finder.
// Holds the array geometry defaults and the one-hot loader state encoding.
package min_max_array_loader_pkg;

    localparam int WIDTH  = 8;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = $clog2(DEPTH);

    // One-hot so that {Qh,Qf,Qi} is the state register itself.
    typedef enum logic [2:0] {
        ST_INI  = 3'b001,
        ST_FILL = 3'b010,
        ST_HOLD = 3'b100
    } loaderState_e;

endpackage

// File: rtl/min_max_array_loader_array_regfile.sv
// DEPTH x WIDTH register array with one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset so that a
// partially or fully loaded array survives a reset of the loader.
module array_regfile
    import min_max_array_loader_pkg::*;
(
    input  logic              Clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write one element per clock when enabled; a read of the same address in
    // that cycle still sees the old value because the read is purely combinational.
    always_ff @(posedge Clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/min_max_array_loader.sv
// Writer side of the array scanned by the min/max finder. Accepts a byte
// stream over valid/ready, fills M[0..DEPTH-1] in order, pulses Start_out
// to the finder, then freezes the array until the finder reports done.
module min_max_array_loader
    import min_max_array_loader_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Load_req,
    input  logic [WIDTH-1:0]  Din,
    input  logic              Din_valid,
    output logic              Din_ready,
    input  logic [ADDR_W-1:0] Rd_addr,
    output logic [WIDTH-1:0]  Rd_data,
    output logic              Start_out,
    input  logic              Finder_done,
    output logic [ADDR_W:0]   Count,
    output logic              Qi,
    output logic              Qf,
    output logic              Qh
);

    loaderState_e      state_q;
    logic [ADDR_W-1:0] wp_q;
    logic [ADDR_W:0]   count_q;
    logic              start_q;
    logic              writeFire;
    logic              lastBeat;

    // Ready is a pure decode of the FILL state so the handshake needs no extra register.
    assign Din_ready = (state_q == ST_FILL);
    assign writeFire = Din_valid && Din_ready;
    assign lastBeat  = (wp_q == ADDR_W'(DEPTH - 1));

    // Controller: one-hot FSM plus write pointer, element count and the Start pulse.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_INI;
            wp_q    <= '0;
            count_q <= '0;
            start_q <= 1'b0;
        end else begin
            start_q <= 1'b0;
            unique case (state_q)
                ST_INI: begin
                    if (Load_req) begin
                        state_q <= ST_FILL;
                        wp_q    <= '0;
                        count_q <= '0;
                    end
                end
                ST_FILL: begin
                    if (writeFire) begin
                        wp_q    <= wp_q + 1'b1;
                        count_q <= count_q + 1'b1;
                        if (lastBeat) begin
                            state_q <= ST_HOLD;
                            start_q <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (Finder_done) begin
                        state_q <= ST_INI;
                    end
                end
                default: begin
                    state_q <= ST_INI;
                end
            endcase
        end
    end

    array_regfile uRegfile (
        .Clk   (Clk),
        .we    (writeFire),
        .waddr (wp_q),
        .wdata (Din),
        .raddr (Rd_addr),
        .rdata (Rd_data)
    );

    assign Start_out    = start_q;
    assign Count        = count_q;
    assign {Qh, Qf, Qi} = state_q;

endmodule

// File: tb/tb_min_max_array_loader.sv
// Randomized self-checking bench for the min/max array loader. The reference
// model is a plain array of expected element values plus the number of
// accepted beats in the current fill.
module tb_min_max_array_loader;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Load_req;
    logic [7:0] Din;
    logic       Din_valid;
    logic       Din_ready;
    logic [3:0] Rd_addr;
    logic [7:0] Rd_data;
    logic       Start_out;
    logic       Finder_done;
    logic [4:0] Count;
    logic       Qi, Qf, Qh;

    int checkCount = 0;
    int passCount  = 0;

    logic [7:0] modelMem   [16];
    bit         modelKnown [16];
    logic [7:0] stimData   [16];

    min_max_array_loader dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Load_req    (Load_req),
        .Din         (Din),
        .Din_valid   (Din_valid),
        .Din_ready   (Din_ready),
        .Rd_addr     (Rd_addr),
        .Rd_data     (Rd_data),
        .Start_out   (Start_out),
        .Finder_done (Finder_done),
        .Count       (Count),
        .Qi          (Qi),
        .Qf          (Qf),
        .Qh          (Qh)
    );

    always #5 Clk = ~Clk;

    // Single comparison point: counts every check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Advance one clock and settle just after the active edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Compare every element with a known expected value against the read port.
    task automatic checkArray(input string tag);
        for (int a = 0; a < 16; a++) begin
            Rd_addr = 4'(a);
            #1;
            if (modelKnown[a]) checkOutput(tag, 32'(Rd_data), 32'(modelMem[a]));
        end
    endtask

    // Let the finder finish: Finder_done for one cycle returns the loader to INI.
    task automatic releaseHold();
        Finder_done = 1'b1;
        tick();
        checkOutput("releaseQi", 32'(Qi), 32'd1);
        Finder_done = 1'b0;
    endtask

    // Issue Load_req, then stream stimData[0..beats-1]. gapMode: 0 continuous,
    // 1 valid every third cycle, 2 random valid. doneEarly raises Finder_done
    // before the last beat so it is already high when HOLD is entered.
    task automatic applyStimulus(input int gapMode, input int beats, input bit doneEarly);
        int  accepted;
        int  cyc;
        bit  valid;
        accepted = 0;
        cyc      = 0;
        Load_req = 1'b1;
        #1;
        checkOutput("iniBeforeLoad", 32'(Qi), 32'd1);
        tick();
        Load_req = 1'b0;
        checkOutput("fillEntered", 32'(Qf), 32'd1);
        checkOutput("fillCount0", 32'(Count), 32'd0);
        while (accepted < beats && cyc < 400) begin
            case (gapMode)
                0:       valid = 1'b1;
                1:       valid = (cyc % 3 == 2);
                default: valid = 1'($urandom_range(0, 1));
            endcase
            Din_valid   = valid;
            Din         = valid ? stimData[accepted] : 8'($urandom);
            Rd_addr     = 4'(accepted);
            Finder_done = doneEarly && (accepted == 15);
            #1;
            checkOutput("readyInFill", 32'(Din_ready), 32'd1);
            checkOutput("noEarlyStart", 32'(Start_out), 32'd0);
            if (modelKnown[accepted]) checkOutput("rdOldValue", 32'(Rd_data), 32'(modelMem[accepted]));
            tick();
            if (valid) begin
                modelMem[accepted]   = stimData[accepted];
                modelKnown[accepted] = 1'b1;
                checkOutput("rdNewValue", 32'(Rd_data), 32'(stimData[accepted]));
                accepted++;
            end
            checkOutput("countTrack", 32'(Count), 32'(accepted));
            cyc++;
        end
        Din_valid = 1'b0;
        if (cyc >= 400) checkOutput("fillTimeout", 32'd0, 32'd1);
        if (beats == 16) begin
            checkOutput("holdEntered", 32'(Qh), 32'd1);
            checkOutput("startPulse", 32'(Start_out), 32'd1);
            checkOutput("holdCount16", 32'(Count), 32'd16);
            checkOutput("holdNotReady", 32'(Din_ready), 32'd0);
            tick();
            checkOutput("startCleared", 32'(Start_out), 32'd0);
            if (doneEarly) begin
                checkOutput("earlyDoneQi", 32'(Qi), 32'd1);
                Finder_done = 1'b0;
            end else begin
                checkOutput("stillHold", 32'(Qh), 32'd1);
            end
        end
    endtask

    // Pulse the asynchronous reset and check that it acts immediately.
    task automatic pulseReset();
        #2;
        Reset = 1'b1;
        #1;
        checkOutput("rstQi", 32'(Qi), 32'd1);
        checkOutput("rstCount", 32'(Count), 32'd0);
        checkOutput("rstStart", 32'(Start_out), 32'd0);
        checkOutput("rstReady", 32'(Din_ready), 32'd0);
        tick();
        Reset = 1'b0;
        tick();
        checkOutput("postRstQi", 32'(Qi), 32'd1);
    endtask

    initial begin
        logic [7:0] expMax, expMin, seenMax, seenMin;

        Reset = 1'b1; Load_req = 1'b0; Din = '0; Din_valid = 1'b0;
        Rd_addr = '0; Finder_done = 1'b0;
        for (int i = 0; i < 16; i++) begin
            modelKnown[i] = 1'b0;
            modelMem[i]   = '0;
        end
        tick(); tick();
        checkOutput("resetQi", 32'(Qi), 32'd1);
        checkOutput("resetQfQh", 32'({Qf, Qh}), 32'd0);
        checkOutput("resetCount", 32'(Count), 32'd0);
        checkOutput("resetStart", 32'(Start_out), 32'd0);
        checkOutput("resetReady", 32'(Din_ready), 32'd0);
        Reset = 1'b0;
        tick();
        checkOutput("idleQi", 32'(Qi), 32'd1);

        // Continuous stream beginning 5, 200.
        for (int i = 0; i < 16; i++) stimData[i] = 8'($urandom);
        stimData[0] = 8'd5;
        stimData[1] = 8'd200;
        applyStimulus(0, 16, 1'b0);
        checkArray("fill1Mem");

        // HOLD ignores data, valid and Load_req.
        Din_valid = 1'b1; Din = 8'hFF; Load_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("holdStays", 32'(Qh), 32'd1);
            checkOutput("holdCountKept", 32'(Count), 32'd16);
            checkOutput("holdNoStart", 32'(Start_out), 32'd0);
        end
        Din_valid = 1'b0; Load_req = 1'b0;
        checkArray("holdFrozen");
        releaseHold();
        tick();
        checkOutput("iniCountKept", 32'(Count), 32'd16);

        // Gapped stream, element k holds k.
        for (int i = 0; i < 16; i++) stimData[i] = 8'(i);
        applyStimulus(1, 16, 1'b0);
        checkArray("gappedMem");
        releaseHold();

        // Read-during-write: M[3] goes 0x11 -> 0xAA, checked inside the stream.
        for (int i = 0; i < 16; i++) stimData[i] = 8'($urandom);
        stimData[3] = 8'h11;
        applyStimulus(2, 16, 1'b0);
        releaseHold();
        for (int i = 0; i < 16; i++) stimData[i] = 8'($urandom);
        stimData[3] = 8'hAA;
        applyStimulus(0, 16, 1'b0);
        checkArray("rawMem");
        releaseHold();

        // Reset after 7 beats keeps the partial data; the next fill restarts at M[0].
        for (int i = 0; i < 16; i++) stimData[i] = 8'($urandom);
        applyStimulus(2, 7, 1'b0);
        pulseReset();
        checkArray("partialMem");
        for (int i = 0; i < 16; i++) stimData[i] = 8'($urandom);
        applyStimulus(0, 16, 1'b1);
        checkArray("afterRstMem");

        // Act as the finder: scan through the read port and compare extremes.
        for (int i = 0; i < 16; i++) stimData[i] = 8'($urandom_range(1, 254));
        stimData[4]  = 8'd0;
        stimData[9]  = 8'd255;
        stimData[15] = 8'd7;
        applyStimulus(2, 16, 1'b0);
        expMax = 8'd0; expMin = 8'd255;
        foreach (modelMem[i]) begin
            if (modelMem[i] > expMax) expMax = modelMem[i];
            if (modelMem[i] < expMin) expMin = modelMem[i];
        end
        seenMax = 8'd0; seenMin = 8'd255;
        for (int a = 0; a < 16; a++) begin
            Rd_addr = 4'(a);
            #1;
            if (Rd_data > seenMax) seenMax = Rd_data;
            if (Rd_data < seenMin) seenMin = Rd_data;
        end
        checkOutput("scanMax", 32'(seenMax), 32'(expMax));
        checkOutput("scanMin", 32'(seenMin), 32'(expMin));
        checkOutput("scanMax255", 32'(seenMax), 32'd255);
        checkOutput("scanMin0", 32'(seenMin), 32'd0);
        releaseHold();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
